// File: rtl/apsk_demap_pkg.sv
// Shared constants and FSM encoding for the APSK soft demapper blocks.
// Build option: define LLR_SAT_EN to clamp LLRs to +/-LLR_CLIP.
package apsk_demap_pkg;

  localparam int WORDLENGTH       = 18;
  localparam int LLR_WORDLENGTH   = 19;
  localparam int SYM_NUM          = 64;
  localparam int BIT_NUM          = 6;
  localparam int LLR_CLIP_DEFAULT = 65535;

  // Symbols folded per SEARCH cycle, and the index bits they span.
  localparam int FOLD_WIDTH = 8;
  localparam int FOLD_BITS  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_CALC   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic int cnt_width(input int syms);
    return (syms / FOLD_WIDTH > 1) ? $clog2(syms / FOLD_WIDTH) : 1;
  endfunction

endpackage

// File: rtl/llr_min_search_if.sv
// Metric-in / LLR-out handshake bundle for llr_min_search.
interface llr_min_search_if
  import apsk_demap_pkg::*;
#(
  parameter int wordlength     = WORDLENGTH,
  parameter int LLR_wordlength = LLR_WORDLENGTH,
  parameter int sym_num        = SYM_NUM,
  parameter int bit_num        = BIT_NUM
);
  logic [sym_num*wordlength-1:0]    metric_i;
  logic                             in_valid;
  logic                             in_ready;
  logic [bit_num*LLR_wordlength-1:0] llr_o;
  logic [bit_num-1:0]               hard_o;
  logic                             out_valid;
  logic                             out_ready;

  modport master (
    output metric_i, in_valid, out_ready,
    input  in_ready, llr_o, hard_o, out_valid
  );

  modport slave (
    input  metric_i, in_valid, out_ready,
    output in_ready, llr_o, hard_o, out_valid
  );
endinterface

// File: rtl/llr_min8.sv
// Eight-input unsigned minimum; on equal values the lowest input index wins.
module llr_min8 #(
  parameter int wordlength = 18
) (
  input  logic [7:0][wordlength-1:0] din,
  output logic [wordlength-1:0]      min_o,
  output logic [2:0]                 idx_o
);

  logic [wordlength-1:0] best;
  logic [2:0]            best_idx;

  always_comb begin
    best     = din[0];
    best_idx = 3'd0;
    // Strict compare keeps the earlier index on ties.
    for (int j = 1; j < 8; j++) begin
      if (din[j] < best) begin
        best     = din[j];
        best_idx = 3'(j);
      end
    end
  end

  assign min_o = best;
  assign idx_o = best_idx;

endmodule

// File: rtl/llr_min_search.sv
// Max-log LLR search: folds 8 metrics per cycle into per-bit minima, then emits LLRs and argmin.
// Build option: LLR_SAT_EN clamps each LLR to [-LLR_CLIP, +LLR_CLIP].
module llr_min_search
  import apsk_demap_pkg::*;
#(
  parameter int wordlength     = WORDLENGTH,
  parameter int LLR_wordlength = LLR_WORDLENGTH,
  parameter int sym_num        = SYM_NUM,
  parameter int bit_num        = BIT_NUM,
  parameter int LLR_CLIP       = LLR_CLIP_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  llr_min_search_if.slave bus
);

  localparam int CNT_W = cnt_width(sym_num);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(sym_num / FOLD_WIDTH - 1);
`ifdef LLR_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  localparam logic signed [LLR_wordlength-1:0] CLIP_P = LLR_wordlength'(LLR_CLIP);
  localparam logic signed [LLR_wordlength-1:0] CLIP_N = -CLIP_P;

  state_t                              state_q, state_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [sym_num-1:0][wordlength-1:0]  metric_q, metric_d;
  logic [bit_num-1:0][wordlength-1:0]  min0_q, min0_d, min1_q, min1_d;
  logic [wordlength-1:0]               best_q, best_d;
  logic [bit_num-1:0]                  arg_q, arg_d, hard_q, hard_d;
  logic [bit_num-1:0][LLR_wordlength-1:0] llr_q, llr_d;
  logic                                in_ready_q, in_ready_d;
  logic                                out_valid_q, out_valid_d;

  logic [FOLD_WIDTH-1:0][wordlength-1:0] grp;
  logic [wordlength-1:0]                 grp_min;
  logic [FOLD_BITS-1:0]                  grp_idx;
  logic [wordlength-1:0]                 cand0 [bit_num];
  logic [wordlength-1:0]                 cand1 [bit_num];
  logic [LLR_wordlength-1:0]             llr_calc [bit_num];

  genvar gi;

  // Current fold group: symbols {cnt, j} for j = 0..7.
  generate
    for (gi = 0; gi < FOLD_WIDTH; gi++) begin : g_grp
      assign grp[gi] = metric_q[{cnt_q, FOLD_BITS'(gi)}];
    end
  endgenerate

  llr_min8 #(
    .wordlength(wordlength)
  ) u_min8 (
    .din  (grp),
    .min_o(grp_min),
    .idx_o(grp_idx)
  );

  // Low bits vary inside a group; high bits are fixed by the counter, so the
  // whole group minimum lands on one side only.
  generate
    for (gi = 0; gi < bit_num; gi++) begin : g_cand
      if (gi < FOLD_BITS) begin : g_lo
        logic [wordlength-1:0] lo0, lo1;
        always_comb begin
          lo0 = '1;
          lo1 = '1;
          for (int j = 0; j < FOLD_WIDTH; j++) begin
            if (j[gi]) begin
              if (grp[j] < lo1) lo1 = grp[j];
            end else begin
              if (grp[j] < lo0) lo0 = grp[j];
            end
          end
        end
        assign cand0[gi] = lo0;
        assign cand1[gi] = lo1;
      end else begin : g_hi
        assign cand0[gi] = cnt_q[gi-FOLD_BITS] ? '1 : grp_min;
        assign cand1[gi] = cnt_q[gi-FOLD_BITS] ? grp_min : '1;
      end
    end
  endgenerate

  generate
    for (gi = 0; gi < bit_num; gi++) begin : g_llr
      logic signed [wordlength:0]       diff;
      logic signed [LLR_wordlength-1:0] diff_ext;
      assign diff     = $signed({1'b0, min1_q[gi]}) - $signed({1'b0, min0_q[gi]});
      assign diff_ext = LLR_wordlength'(diff);
      assign llr_calc[gi] = (SAT_EN && diff_ext > CLIP_P) ? CLIP_P :
                            (SAT_EN && diff_ext < CLIP_N) ? CLIP_N : diff_ext;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    metric_d    = metric_q;
    min0_d      = min0_q;
    min1_d      = min1_q;
    best_d      = best_q;
    arg_d       = arg_q;
    hard_d      = hard_q;
    llr_d       = llr_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          metric_d   = bus.metric_i;
          cnt_d      = '0;
          min0_d     = '1;
          min1_d     = '1;
          best_d     = '1;
          arg_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        for (int k = 0; k < bit_num; k++) begin
          if (cand0[k] < min0_q[k]) min0_d[k] = cand0[k];
          if (cand1[k] < min1_q[k]) min1_d[k] = cand1[k];
        end
        // Strict compare: an equal value in a later group never steals the argmin.
        if (grp_min < best_q) begin
          best_d = grp_min;
          arg_d  = bit_num'({cnt_q, grp_idx});
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_CALC;
      end
      ST_CALC: begin
        for (int k = 0; k < bit_num; k++) llr_d[k] = llr_calc[k];
        hard_d      = arg_q;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      metric_q    <= '0;
      min0_q      <= '1;
      min1_q      <= '1;
      best_q      <= '1;
      arg_q       <= '0;
      hard_q      <= '0;
      llr_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      metric_q    <= metric_d;
      min0_q      <= min0_d;
      min1_q      <= min1_d;
      best_q      <= best_d;
      arg_q       <= arg_d;
      hard_q      <= hard_d;
      llr_q       <= llr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.hard_o    = hard_q;
  assign bus.llr_o     = llr_q;

endmodule

// File: tb/tb_llr_min_search.sv
// Directed self-checking bench for llr_min_search with hand-computed LLR/argmin vectors.
module tb_llr_min_search;
  import apsk_demap_pkg::*;

  localparam int WL = WORDLENGTH;
  localparam int LW = LLR_WORDLENGTH;
  localparam int NS = SYM_NUM;
  localparam int NB = BIT_NUM;
`ifdef LLR_SAT_EN
  localparam int BIG_LLR = 65535;
`else
  localparam int BIG_LLR = 262143;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  llr_min_search_if #(.wordlength(WL), .LLR_wordlength(LW), .sym_num(NS), .bit_num(NB)) bus ();

  llr_min_search #(
    .wordlength(WL), .LLR_wordlength(LW), .sym_num(NS), .bit_num(NB), .LLR_CLIP(65535)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [NS-1:0][WL-1:0] m;
  int exp_llr [NB];
  int nres;
  int exp_idx;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] llr_of(input int k);
    logic signed [LW-1:0] v;
    v = bus.llr_o[k*LW +: LW];
    return 64'(v);
  endfunction

  task automatic fill(input int v);
    for (int s = 0; s < NS; s++) m[s] = WL'(v);
  endtask

  task automatic do_accept(input string tag);
    bus.metric_i = m;
    bus.in_valid = 1'b1;
    check({tag, "_in_ready"}, 64'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // out_valid must rise in the 10th cycle, i.e. after the 9th edge past accept.
  task automatic wait_result(input string tag);
    int lat;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 9);
  endtask

  task automatic check_result(input string tag, input int exp_hard);
    for (int k = 0; k < NB; k++)
      check($sformatf("%s_llr%0d", tag, k), llr_of(k), 64'(exp_llr[k]));
    check({tag, "_hard"}, 64'(bus.hard_o), 64'(exp_hard));
    $display("txn %s hard=%0d llr0=%0d llr5=%0d", tag, bus.hard_o, llr_of(0), llr_of(NB-1));
  endtask

  task automatic release_out(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_idle_valid"}, 64'(bus.out_valid), 0);
    check({tag, "_idle_ready"}, 64'(bus.in_ready), 1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    fill(0);
    bus.metric_i  = m;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 1);
    check("rst_out_valid", 64'(bus.out_valid), 0);
    check("rst_llr_bus", 64'(bus.llr_o == '0), 1);
    check("rst_hard", 64'(bus.hard_o), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // All equal metrics.
    fill(100);
    do_accept("flat");
    check("flat_busy_ready", 64'(bus.in_ready), 0);
    wait_result("flat");
    exp_llr = '{0, 0, 0, 0, 0, 0};
    check_result("flat", 0);
    release_out("flat");

    // Single minimum at 37 = 6'b100101.
    fill(1000);
    m[37] = '0;
    do_accept("sym37");
    wait_result("sym37");
    exp_llr = '{-1000, 1000, -1000, 1000, 1000, -1000};
    check_result("sym37", 37);
    release_out("sym37");

    // Full-range metrics: largest positive LLR.
    fill(262143);
    m[0] = '0;
    do_accept("big");
    wait_result("big");
    exp_llr = '{BIG_LLR, BIG_LLR, BIG_LLR, BIG_LLR, BIG_LLR, BIG_LLR};
    check_result("big", 0);
    release_out("big");

    // Equal minima at 10 and 50 in different groups.
    fill(200);
    m[10] = WL'(5);
    m[50] = WL'(5);
    do_accept("tie");
    wait_result("tie");
    exp_llr = '{195, -195, 195, 0, 0, 0};
    check_result("tie", 10);
    release_out("tie");

    // Descending metrics: minimum in the last fold group.
    for (int s = 0; s < NS; s++) m[s] = WL'(1000 - s);
    do_accept("desc");
    wait_result("desc");
    exp_llr = '{-1, -2, -4, -8, -16, -32};
    check_result("desc", 63);
    release_out("desc");

    // Ascending metrics with the consumer stalling for 5 cycles.
    for (int s = 0; s < NS; s++) m[s] = WL'(s + 10);
    bus.out_ready = 1'b0;
    do_accept("hold");
    wait_result("hold");
    exp_llr = '{1, 2, 4, 8, 16, 32};
    check_result("hold", 0);
    repeat (5) begin
      @(posedge clk);
      #1;
      check("hold_valid", 64'(bus.out_valid), 1);
      check("hold_in_ready", 64'(bus.in_ready), 0);
      check("hold_llr5", llr_of(5), 32);
      check("hold_llr2", llr_of(2), 4);
    end
    bus.out_ready = 1'b1;
    release_out("hold");

    // Reset in SEARCH with counter 4, then a clean set.
    fill(5);
    do_accept("abort");
    repeat (4) @(posedge clk);
    #1;
    check("abort_busy", 64'(bus.in_ready), 0);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 64'(bus.out_valid), 0);
    check("abort_in_ready", 64'(bus.in_ready), 1);
    check("abort_llr0", llr_of(0), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fill(1000);
    m[37] = '0;
    do_accept("after_rst");
    wait_result("after_rst");
    exp_llr = '{-1000, 1000, -1000, 1000, 1000, -1000};
    check_result("after_rst", 37);
    release_out("after_rst");

    // in_valid held high with a different set each cycle.
    nres = 0;
    for (int j = 0; j <= 32; j++) begin
      fill(1000);
      m[j % NS] = '0;
      bus.metric_i = m;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) begin
        exp_idx = 11 * nres;
        check("stream_cycle", 64'(j), 64'(9 + 11 * nres));
        for (int k = 0; k < NB; k++)
          exp_llr[k] = ((exp_idx >> k) & 1) != 0 ? -1000 : 1000;
        check_result($sformatf("stream%0d", nres), exp_idx);
        nres++;
      end
    end
    bus.in_valid = 1'b0;
    check("stream_results", 64'(nres), 3);
    @(posedge clk);
    #1;
    check("stream_end_ready", 64'(bus.in_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
